// File: rtl/sha256_round_driver.sv
// Sequencer for the 5-stage SHA-256 round core. It issues 64 rounds per block, keeps the
// 16-word schedule window, and adds the chaining value into the final letters.
`timescale 1ns/1ps
module sha256_round_driver #(
  parameter int ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0][31:0] i_block,
  input  logic [7:0][31:0]  i_hash,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [7:0][31:0]  o_hash,
  output logic              o_hash_valid,
  output logic [7:0][31:0]  o_core_letters,
  output logic [5:0]        o_core_counter,
  output logic [3:0][31:0]  o_core_w,
  output logic              o_core_ready,
  input  logic [7:0][31:0]  i_core_letters,
  input  logic              i_core_letters_valid,
  input  logic [31:0]       i_core_w,
  input  logic              i_core_w_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  state_t            state, state_nxt;
  logic [15:0][31:0] window, window_nxt;
  logic [7:0][31:0]  chain, chain_nxt;
  logic [7:0][31:0]  letters_nxt, hash_nxt;
  logic [5:0]        t_nxt;
  logic [3:0][31:0]  taps_nxt;
  logic              hash_valid_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    window_nxt     = window;
    chain_nxt      = chain;
    letters_nxt    = o_core_letters;
    t_nxt          = o_core_counter;
    hash_nxt       = o_hash;
    hash_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid) begin
          window_nxt  = i_block;
          chain_nxt   = i_hash;
          letters_nxt = i_hash;
          t_nxt       = '0;
          state_nxt   = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // The first 16 rounds read the message words in place, so the window only slides afterwards.
        if (i_core_w_valid && o_core_counter >= 6'd16)
          window_nxt = {i_core_w, window[15:1]};
        if (i_core_letters_valid) begin
          letters_nxt = i_core_letters;
          if (o_core_counter == LAST) begin
            for (int i = 0; i < 8; i++)
              hash_nxt[i] = chain[i] + i_core_letters[i];
            hash_valid_nxt = 1'b1;
            state_nxt      = IDLE;
          end else begin
            t_nxt     = o_core_counter + 6'd1;
            state_nxt = ISSUE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // With only the W[t-16] slot populated, the core's schedule sum reduces to M_t.
    taps_nxt = '0;
    if (t_nxt < 6'd16)
      taps_nxt[0] = window_nxt[t_nxt[3:0]];
    else
      taps_nxt = {window_nxt[14], window_nxt[9], window_nxt[1], window_nxt[0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      window         <= '0;
      chain          <= '0;
      o_core_letters <= '0;
      o_core_counter <= '0;
      o_core_w       <= '0;
      o_core_ready   <= 1'b0;
      o_hash         <= '0;
      o_hash_valid   <= 1'b0;
      o_ready        <= 1'b1;
    end else begin
      window         <= window_nxt;
      chain          <= chain_nxt;
      o_core_letters <= letters_nxt;
      o_core_counter <= t_nxt;
      o_hash         <= hash_nxt;
      o_hash_valid   <= hash_valid_nxt;
      o_ready        <= (state_nxt == IDLE);
      o_core_ready   <= (state_nxt == ISSUE);
      if (state_nxt == ISSUE)
        o_core_w <= taps_nxt;
    end
  end

endmodule

// File: tb/tb_sha256_round_driver.sv
// Bench for sha256_round_driver: a behavioural 5-stage round core plus a digest/latency scoreboard.
`timescale 1ns/1ps
module tb_sha256_round_driver;

  logic              clk;
  logic              rst;
  logic [15:0][31:0] blk;
  logic [7:0][31:0]  ih;
  logic              iv;
  logic              o_ready;
  logic [7:0][31:0]  o_hash;
  logic              o_hash_valid;
  logic [7:0][31:0]  o_core_letters;
  logic [5:0]        o_core_counter;
  logic [3:0][31:0]  o_core_w;
  logic              o_core_ready;
  logic [7:0][31:0]  c_letters;
  logic              c_lv, c_wv, spur_lv, spur_wv;
  logic [31:0]       c_w;

  sha256_round_driver #(.ROUNDS(64)) dut (
    .clk(clk), .rst(rst),
    .i_block(blk), .i_hash(ih), .i_valid(iv), .o_ready(o_ready),
    .o_hash(o_hash), .o_hash_valid(o_hash_valid),
    .o_core_letters(o_core_letters), .o_core_counter(o_core_counter),
    .o_core_w(o_core_w), .o_core_ready(o_core_ready),
    .i_core_letters(c_letters), .i_core_letters_valid(c_lv | spur_lv),
    .i_core_w(c_w), .i_core_w_valid(c_wv | spur_wv)
  );

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [255:0] IV  = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                  32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [255:0] ABC = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                                  32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
  localparam logic [255:0] TWO = {32'h19db06c1, 32'hf6ecedd4, 32'h64ff2167, 32'ha33ce459,
                                  32'h0c3e6039, 32'he5c02693, 32'hd20638b8, 32'h248d6a61};

  typedef struct packed {
    logic         chk;
    logic [255:0] h;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   hv_cnt = 0;
  bit   probe_en = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Behavioural core: samples an issue, returns W three edges and letters five edges later.
  initial begin
    int cnt;
    bit prev_rdy;
    logic [31:0] w, t1, t2;
    logic [7:0][31:0] l, nl;
    logic [3:0][31:0] tw;
    logic [3:0][31:0] e16;
    cnt = -1; prev_rdy = 1'b0;
    c_lv = 1'b0; c_wv = 1'b0; c_w = '0; c_letters = '0;
    forever begin
      @(negedge clk);
      c_lv = 1'b0;
      c_wv = 1'b0;
      if (rst) begin
        cnt = -1;
        prev_rdy = 1'b0;
      end else begin
        if (cnt >= 0) cnt++;
        if (cnt == 3) c_wv = 1'b1;
        if (cnt == 5) begin
          c_lv = 1'b1;
          cnt = -1;
        end
        if (o_core_ready) begin
          chk("issue_one_cycle", 256'(prev_rdy), 256'(0));
          if (probe_en && o_core_counter == 6'd16) begin
            e16 = '0;
            e16[0] = 32'h61626380;
            chk("taps_t16", 256'(o_core_w), 256'(e16));
          end
          tw = o_core_w;
          l  = o_core_letters;
          w  = (rotr(tw[3], 17) ^ rotr(tw[3], 19) ^ (tw[3] >> 10)) + tw[2]
             + (rotr(tw[1], 7) ^ rotr(tw[1], 18) ^ (tw[1] >> 3)) + tw[0];
          t1 = l[7] + (rotr(l[4], 6) ^ rotr(l[4], 11) ^ rotr(l[4], 25))
             + ((l[4] & l[5]) ^ (~l[4] & l[6])) + K[o_core_counter] + w;
          t2 = (rotr(l[0], 2) ^ rotr(l[0], 13) ^ rotr(l[0], 22))
             + ((l[0] & l[1]) ^ (l[0] & l[2]) ^ (l[1] & l[2]));
          nl[7] = l[6]; nl[6] = l[5]; nl[5] = l[4]; nl[4] = l[3] + t1;
          nl[3] = l[2]; nl[2] = l[1]; nl[1] = l[0]; nl[0] = t1 + t2;
          c_w = w;
          c_letters = nl;
          cnt = 0;
        end
        prev_rdy = o_core_ready;
      end
    end
  end

  // Scoreboard: accept times and expected digests are popped on each o_hash_valid.
  initial begin
    bit   prev_hv;
    exp_t e;
    int   a;
    prev_hv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && iv && o_ready) begin
        acc_q.push_back(cyc + 1);
        acc_cnt++;
      end
      if (prev_hv) chk("hv_width", 256'(o_hash_valid), 256'(0));
      if (o_hash_valid) begin
        hv_cnt++;
        chk("hv_expected", 256'(exp_q.size() > 0 && acc_q.size() > 0), 256'(1));
        if (exp_q.size() > 0 && acc_q.size() > 0) begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("latency", 256'(cyc - a), 256'(384));
          chk("ready_with_hv", 256'(o_ready), 256'(1));
          if (e.chk) chk("digest", o_hash, e.h);
        end
      end
      prev_hv = o_hash_valid;
    end
  end

  task automatic wait_hv(input int limit, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (o_hash_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, 256'(got), 256'(1));
  endtask

  task automatic check_idle(input string pfx);
    chk({pfx, "_ready"},   256'(o_ready), 256'(1));
    chk({pfx, "_hash"},    o_hash, 256'(0));
    chk({pfx, "_hv"},      256'(o_hash_valid), 256'(0));
    chk({pfx, "_cready"},  256'(o_core_ready), 256'(0));
    chk({pfx, "_counter"}, 256'(o_core_counter), 256'(0));
    chk({pfx, "_letters"}, o_core_letters, 256'(0));
    chk({pfx, "_w"},       256'(o_core_w), 256'(0));
  endtask

  function automatic logic [15:0][31:0] abc_block();
    logic [15:0][31:0] b;
    b = '0;
    b[0]  = 32'h61626380;
    b[15] = 32'h00000018;
    return b;
  endfunction

  initial begin
    logic [3:0][31:0] ew;
    bit got;
    rst = 1'b1; iv = 1'b0; blk = '0; ih = '0; spur_lv = 1'b0; spur_wv = 1'b0;
    @(posedge clk); #1;
    check_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Spurious core strobes while idle must be ignored.
    @(posedge clk); #1;
    spur_lv = 1'b1; spur_wv = 1'b1;
    @(posedge clk); #1;
    spur_lv = 1'b0; spur_wv = 1'b0;
    check_idle("spurious");
    @(posedge clk); #1;
    chk("spurious_hv_later", 256'(o_hash_valid), 256'(0));

    // "abc" with i_valid held and garbage inputs after accept.
    blk = abc_block(); ih = IV; iv = 1'b1; probe_en = 1'b1;
    exp_q.push_back('{chk: 1'b1, h: ABC});
    @(posedge clk); #1;
    ew = '0;
    ew[0] = 32'h61626380;
    chk("r0_cready",  256'(o_core_ready), 256'(1));
    chk("r0_counter", 256'(o_core_counter), 256'(0));
    chk("r0_w",       256'(o_core_w), 256'(ew));
    chk("r0_letters", o_core_letters, IV);
    chk("r0_busy",    256'(o_ready), 256'(0));
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    for (int i = 0; i < 8; i++) ih[i] = $urandom;
    wait_hv(450, "abc_held_timeout");
    iv = 1'b0;
    probe_en = 1'b0;
    chk("held_single_accept", 256'(acc_cnt), 256'(1));

    // Reset asserted during round 30 aborts the block.
    @(posedge clk); #1;
    blk = abc_block(); ih = IV; iv = 1'b1;
    exp_q.push_back('{chk: 1'b1, h: ABC});
    @(posedge clk); #1;
    iv = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (o_core_counter == 6'd30 && !o_core_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("reach_round30", 256'(got), 256'(1));
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle("midreset");
    begin
      int hv_before;
      hv_before = hv_cnt;
      repeat (450) @(posedge clk);
      #1;
      chk("no_hv_after_abort", 256'(hv_cnt), 256'(hv_before));
    end

    // Fresh "abc" after the abort.
    blk = abc_block(); ih = IV; iv = 1'b1;
    exp_q.push_back('{chk: 1'b1, h: ABC});
    @(posedge clk); #1;
    iv = 1'b0;
    wait_hv(450, "abc_after_reset_timeout");

    // Two-block message, second block fed back-to-back in the o_hash_valid cycle.
    @(posedge clk); #1;
    blk = '0;
    blk[0]  = 32'h61626364; blk[1]  = 32'h62636465; blk[2]  = 32'h63646566; blk[3]  = 32'h64656667;
    blk[4]  = 32'h65666768; blk[5]  = 32'h66676869; blk[6]  = 32'h6768696a; blk[7]  = 32'h68696a6b;
    blk[8]  = 32'h696a6b6c; blk[9]  = 32'h6a6b6c6d; blk[10] = 32'h6b6c6d6e; blk[11] = 32'h6c6d6e6f;
    blk[12] = 32'h6d6e6f70; blk[13] = 32'h6e6f7071; blk[14] = 32'h80000000; blk[15] = 32'h00000000;
    ih = IV; iv = 1'b1;
    exp_q.push_back('{chk: 1'b0, h: '0});
    @(posedge clk); #1;
    iv = 1'b0;
    wait_hv(450, "blk1_timeout");
    blk = '0;
    blk[15] = 32'h000001c0;
    ih = o_hash; iv = 1'b1;
    exp_q.push_back('{chk: 1'b1, h: TWO});
    @(posedge clk); #1;
    iv = 1'b0;
    chk("b2b_accepted", 256'(o_core_ready), 256'(1));
    wait_hv(450, "blk2_timeout");

    repeat (5) @(posedge clk);
    #1;
    chk("total_accepts", 256'(acc_cnt), 256'(5));
    chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_round_driver.md
Name: sha256_round_driver

Overview:
Initiator and sequencer for the 5-stage sha256 round core. It accepts one 512-bit message block plus an incoming chaining hash, then issues all 64 rounds to the core one at a time, waiting for each round's result before issuing the next. It keeps the 16-word message-schedule window, performs the final Davies-Meyer addition, and returns the updated 256-bit hash. It sits between the block/padding front end and the sha256 core instance.

Parameters:
ROUNDS, 64, number of rounds per block; the round counter is 6 bits, so 64 is the only supported value.

Ports:
clk  input  1  clock; the only clock in the block
rst  input  1  synchronous, active-high reset
i_block  input  32x[15:0]  message words; [0]=M0 (first word), [15]=M15
i_hash  input  32x[7:0]  chaining value; [0]=H0 (a) ... [7]=H7 (h)
i_valid  input  1  block request; accepted when i_valid && o_ready
o_ready  output  1  idle, able to accept a block
o_hash  output  32x[7:0]  updated hash; [0]=H0
o_hash_valid  output  1  one-cycle pulse; o_hash is valid in that cycle and held afterwards
o_core_letters  output  32x[7:0]  working variables to core; a at [0], h at [7]
o_core_counter  output  6  round index t
o_core_w  output  32x[3:0]  schedule taps: [0]=W[t-16], [1]=W[t-15], [2]=W[t-7], [3]=W[t-2]
o_core_ready  output  1  one-cycle issue strobe to core
i_core_letters  input  32x[7:0]  round result from core
i_core_letters_valid  input  1  round result valid
i_core_w  input  32  computed W[t] from core
i_core_w_valid  input  1  W[t] valid

Behaviour:
- Reset, synchronous: state=IDLE; o_ready=1; o_hash=0; o_hash_valid=0; o_core_ready=0; o_core_counter=0; o_core_letters=0; o_core_w=0; window=0. A reset asserted mid-block aborts the block; no o_hash_valid is produced. The core shares the rst net.
- All outputs are registered.
- FSM states:
  - IDLE: o_ready=1. On i_valid: window[0..15] <= M0..M15; H <= i_hash; letters <= i_hash; t <= 0; go to ISSUE.
  - ISSUE: o_core_ready=1 for exactly one cycle, with letters, t and taps driven; go to WAIT.
  - WAIT: outputs are held stable.
    - On i_core_w_valid with t>=16: window shifts; window[0] is dropped and i_core_w enters at [15].
    - On i_core_letters_valid: letters <= i_core_letters. If t==63, o_hash[i] <= H[i] + i_core_letters[i] (mod 2^32, per word), o_hash_valid pulses, go to IDLE. Otherwise t <= t+1 and go to ISSUE.
- Window index mapping: window[k] holds W[t-16+k].
- Taps for t<16: the window is never shifted. Drive o_core_w = {0, 0, 0, window[t]}. With these inputs the core's computed W equals M_t (sigma(0)=0), so no mux is needed inside the core.
- Taps for t>=16: o_core_w = {window[14], window[9], window[1], window[0]}.
- Timing: the core returns W at issue+3 and letters at issue+5. The driver samples letters one cycle later, so each round takes 6 cycles.
- Latency: accept edge E0; round t is sampled by the core at E(1+6t); the last result is sampled at E384. o_hash_valid is high in the cycle after E384, and o_ready is high in that same cycle.
- Ignored inputs:
  - i_valid while busy (o_ready=0).
  - i_core_*_valid in IDLE or ISSUE.
  - i_core_w_valid when t<16.
- Back-to-back blocks: the front end feeds o_hash back into i_hash. A new i_valid is accepted in the same cycle o_hash_valid is high, and it must use the new o_hash.
- No flow control on the output: o_hash_valid is a pulse and the consumer must capture it.

Test Plan:
- "abc" single block: i_hash=IV (6a09e667,bb67ae85,3c6ef372,a54ff53a,510e527f,9b05688c,1f83d9ab,5be0cd19); block=61626380, 0 x14, 00000018 -> o_hash = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; o_hash_valid exactly 384 cycles after the accept edge, one cycle wide.
- Round-0 probe, same stimulus -> first o_core_ready has counter=0, o_core_w={0,0,0,61626380}, letters=IV. The core's o_w at t=16 sample equals 61626380 + s0(0) + 0 + s1(0).
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", second block fed on the o_hash_valid cycle -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- i_valid held high for the whole of the "abc" run with garbage data after accept -> single result identical to the "abc" digest; no second accept until o_ready returns.
- rst pulsed for 1 cycle at round 30 -> all outputs 0, o_ready=1 next cycle, no o_hash_valid; a fresh "abc" block then yields the correct digest.
- Spurious i_core_letters_valid pulsed in IDLE -> no state change; o_hash_valid stays 0.
